dff_pipe_sync: RTL and testbench

//  Parametrised register pipeline: DEPTH stages of WIDTH-bit D flip-flops, one clock, synchronous active-high reset.
//  Per-stage valid bits, global advance enable (stall), flush, and occupancy count.

---
 rtl/dff_pipe_sync.sv | 52 +++++
 tb/tb_dff_pipe_sync.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_sync.sv
// dff_pipe_sync: parametrised DEPTH-stage register pipeline with per-stage valid, stall, flush and occupancy count
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (data <= RESET_VAL, valids and count cleared)
//   en         advance enable: 1 shifts every stage by one, 0 holds everything
//   flush      synchronous clear of all valid bits and count; data stages keep their values
//   in_valid   valid qualifier for D
//   D          input data captured into stage 0 on an enabled edge
//   Q          data of the last stage
//   out_valid  valid bit of the last stage
//   count      number of stages currently holding valid data (0..DEPTH)
module dff_pipe_sync #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           D,
   output logic [WIDTH-1:0]           Q,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] valid;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
         valid <= '0;
         count <= '0;
      end else if (flush) begin
         valid <= '0;
         count <= '0;
      end else if (en) begin
         // data captures D even for bubbles; only the valid bit marks them
         data[0]  <= D;
         valid[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data[i]  <= data[i-1];
            valid[i] <= valid[i-1];
         end
         // the word leaving the last stage is the one that was out_valid before this edge
         count <= count + CW'(in_valid) - CW'(valid[DEPTH-1]);
      end
   end
   assign Q         = data[DEPTH-1];
   assign out_valid = valid[DEPTH-1];
endmodule

// File: tb/tb_dff_pipe_sync.sv
// tb_dff_pipe_sync: self-checking bench for dff_pipe_sync (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5)
module tb_dff_pipe_sync;
   logic       clk = 1'b0;
   logic       reset = 1'b0, en = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [7:0] D = '0;
   logic [7:0] Q;
   logic       out_valid;
   logic [2:0] count;
   int         checks = 0, errors = 0;
   logic [7:0] m_data [4];
   logic [3:0] m_valid = '0;
   logic [7:0] sb [$];
   bit         pre_chk = 1'b0;
   int         max_cnt = 0;
   typedef struct {
      bit         r, f, e, iv;
      logic [7:0] d;
      logic [7:0] q;
      bit         ov;
      int         cnt;
   } vec_t;
   vec_t vecs [10];

   dff_pipe_sync #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
      .D(D), .Q(Q), .out_valid(out_valid), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, f, e, iv, input logic [7:0] d);
      logic [7:0] w;
      reset = r; flush = f; en = e; in_valid = iv; D = d;
      #2;
      if (pre_chk) chk("pre_edge_hold_q", Q, m_data[3]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 4; i++) m_data[i] = 8'hA5;
         m_valid = '0;
         sb.delete();
      end else if (f) begin
         m_valid = '0;
         sb.delete();
      end else if (e) begin
         for (int i = 3; i > 0; i--) m_data[i] = m_data[i-1];
         m_data[0] = d;
         m_valid = {m_valid[2:0], iv};
         if (iv) sb.push_back(d);
      end
      #1;
      pre_chk = 1'b1;
      chk("q", Q, m_data[3]);
      chk("out_valid", out_valid, m_valid[3]);
      chk("count_popcount", count, $countones(m_valid));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (!r && !f && e && out_valid) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            w = sb.pop_front();
            chk("sb_word", Q, w);
         end
      end
   endtask

   initial begin
      bit   seen;
      int   first;
      logic [2:0] pat;
      vecs[0] = '{1, 0, 0, 0, 8'h00, 8'hA5, 0, 0};
      vecs[1] = '{1, 0, 0, 0, 8'h00, 8'hA5, 0, 0};
      vecs[2] = '{0, 0, 1, 1, 8'h01, 8'hA5, 0, 1};
      vecs[3] = '{0, 0, 1, 1, 8'h02, 8'hA5, 0, 2};
      vecs[4] = '{0, 0, 1, 1, 8'h03, 8'hA5, 0, 3};
      vecs[5] = '{0, 0, 1, 1, 8'h04, 8'h01, 1, 4};
      vecs[6] = '{0, 0, 1, 1, 8'h05, 8'h02, 1, 4};
      vecs[7] = '{0, 0, 1, 1, 8'h06, 8'h03, 1, 4};
      vecs[8] = '{0, 0, 1, 1, 8'h07, 8'h04, 1, 4};
      vecs[9] = '{0, 0, 1, 1, 8'h08, 8'h05, 1, 4};
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].r, vecs[i].f, vecs[i].e, vecs[i].iv, vecs[i].d);
         chk($sformatf("tbl%0d_q", i), Q, vecs[i].q);
         chk($sformatf("tbl%0d_ov", i), out_valid, vecs[i].ov);
         chk($sformatf("tbl%0d_cnt", i), count, vecs[i].cnt);
      end
      // reset raised mid-cycle: Q must hold until the edge
      reset = 1'b1;
      #2;
      chk("rst_midcycle_hold_q", Q, 8'h05);
      step(1, 0, 0, 0, 8'h00);
      chk("rst_q", Q, 8'hA5);
      chk("rst_cnt", count, 0);
      // word, bubble, word
      step(0, 1, 0, 0, 8'h00);
      max_cnt = 0;
      pat = '0;
      step(0, 0, 1, 1, 8'h10);
      step(0, 0, 1, 0, 8'h20);
      step(0, 0, 1, 1, 8'h30);
      for (int i = 4; i <= 7; i++) begin
         step(0, 0, 1, 0, 8'h00);
         if (i >= 4 && i <= 6) pat[6-i] = out_valid;
         if (i == 4) chk("bubble_first_q", Q, 8'h10);
         if (i == 6) chk("bubble_third_q", Q, 8'h30);
      end
      chk("bubble_ov_pattern", pat, 3'b101);
      chk("bubble_max_cnt_le2", max_cnt <= 2, 1);
      // stall
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 1, 1, 8'h41);
      step(0, 0, 1, 1, 8'h42);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hFF);
      chk("stall_cnt", count, 2);
      chk("stall_ov", out_valid, 0);
      seen = 0;
      first = 0;
      for (int n = 6; n <= 20 && !seen; n++) begin
         step(0, 0, 1, 0, 8'h00);
         if (out_valid) begin
            seen = 1;
            first = n;
            chk("stall_first_q", Q, 8'h41);
         end
      end
      chk("stall_latency_edges", first, 7);
      step(0, 0, 1, 0, 8'h00);
      chk("stall_second_q", Q, 8'h42);
      chk("stall_second_ov", out_valid, 1);
      step(0, 0, 1, 0, 8'h00);
      chk("stall_no_dup", out_valid, 0);
      // flush with full pipe
      step(0, 0, 1, 1, 8'h11);
      step(0, 0, 1, 1, 8'h22);
      step(0, 0, 1, 1, 8'h33);
      step(0, 0, 1, 1, 8'h44);
      chk("full_q", Q, 8'h11);
      chk("full_cnt", count, 4);
      step(0, 1, 1, 1, 8'h55);
      chk("flush_ov", out_valid, 0);
      chk("flush_cnt", count, 0);
      chk("flush_q_kept", Q, 8'h11);
      step(0, 0, 1, 1, 8'h66);
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 1, 0, 8'h00);
      chk("post_flush_not_yet", out_valid, 0);
      step(0, 0, 1, 0, 8'h00);
      chk("post_flush_q", Q, 8'h66);
      chk("post_flush_ov", out_valid, 1);
      // reset beats flush and en
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'h70 + 8'(i));
      step(1, 1, 1, 1, 8'h77);
      chk("prio_q", Q, 8'hA5);
      chk("prio_cnt", count, 0);
      chk("prio_ov", out_valid, 0);
      // random run against the model
      for (int i = 0; i < 1000; i++)
         step($urandom_range(99) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
              1'($urandom_range(1)), 8'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
